// File: rtl/ram_latency_model.sv
// ram_latency_model
//   Word-organised main-memory model with a programmable access latency.
//   A CPU-side request (ramREN/ramWEN) held steady spends LAT cycles in
//   BUSY, then one cycle in ACCESS. Read data appears in that ACCESS cycle.
//   Write data commits at the clock edge that ends the ACCESS cycle.
//   A side-band debug write port preloads memory while the CPU port is idle.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   ramREN, ramWEN      read / write request from the memory controller
//   ramaddr, ramstore   byte address (bits [1:0] ignored) and write data
//   ramload             read data; non-zero only in ACCESS of a read
//   ramstate            FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   dbg_WEN, dbg_addr,  debug write request, byte address and data
//   dbg_store
//   dbg_wait            high while a held debug write is not accepted
module ram_latency_model #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  input  logic        dbg_WEN,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_store,
  output logic        dbg_wait
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_C = 4'(LAT);
  localparam logic [31:0] DEPTH_C = 32'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [3:0]  cnt_q, cnt_d;
  logic        tracked_valid_q, tracked_valid_d;
  logic [29:0] tracked_addr_q, tracked_addr_d;
  logic        tracked_op_q, tracked_op_d;

  logic [29:0] word_idx;
  logic [29:0] dbg_idx;
  logic        req;
  logic        in_range;
  logic        dbg_in_range;
  logic        match;
  logic [3:0]  eff;
  ramstate_t   state;
  logic        dbg_accept;

  // Byte-lane bits of the addresses are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ramaddr[1:0], dbg_addr[1:0]};

  assign word_idx     = ramaddr[31:2];
  assign dbg_idx      = dbg_addr[31:2];
  assign req          = ramREN | ramWEN;
  assign in_range     = ({2'b00, word_idx} < DEPTH_C);
  assign dbg_in_range = ({2'b00, dbg_idx} < DEPTH_C);

  // Progress only counts if the same address and operation are still being
  // requested; any change restarts the count in the same cycle.
  assign match = tracked_valid_q & (word_idx == tracked_addr_q) & (ramWEN == tracked_op_q);
  assign eff   = match ? cnt_q : 4'd0;

  always_comb begin
    state = BUSY;
    if ((ramREN & ramWEN) | (req & ~in_range)) begin
      state = ERROR;
    end else if (!req) begin
      state = FREE;
    end else if (eff == LAT_C) begin
      state = ACCESS;
    end
  end

  assign ramstate   = state;
  assign dbg_accept = dbg_WEN & (state == FREE);
  assign dbg_wait   = dbg_WEN & ~dbg_accept;

  // ACCESS excludes ERROR, so the index is guaranteed in range here.
  always_comb begin
    ramload = 32'd0;
    if (state == ACCESS && ramREN) begin
      ramload = mem[word_idx[AW-1:0]];
    end
  end

  always_comb begin
    cnt_d           = 4'd0;
    tracked_valid_d = 1'b0;
    tracked_addr_d  = tracked_addr_q;
    tracked_op_d    = tracked_op_q;
    if (state == BUSY) begin
      cnt_d           = eff + 4'd1;
      tracked_valid_d = 1'b1;
      tracked_addr_d  = word_idx;
      tracked_op_d    = ramWEN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q           <= 4'd0;
      tracked_valid_q <= 1'b0;
      tracked_addr_q  <= 30'd0;
      tracked_op_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      cnt_q           <= cnt_d;
      tracked_valid_q <= tracked_valid_d;
      tracked_addr_q  <= tracked_addr_d;
      tracked_op_q    <= tracked_op_d;
      if (state == ACCESS && ramWEN) begin
        mem[word_idx[AW-1:0]] <= ramstore;
      end
      // Debug acceptance implies no CPU request, so the two writes never collide.
      // Out-of-range debug addresses are accepted but dropped.
      if (dbg_accept && dbg_in_range) begin
        mem[dbg_idx[AW-1:0]] <= dbg_store;
      end
    end
  end

endmodule

// File: tb/tb_ram_latency_model.sv
module tb_ram_latency_model;

  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

  logic        clk;
  logic        rst;
  // LAT=2 instance
  logic        ren_a, wen_a, dwen_a, dwait_a;
  logic [31:0] addr_a, store_a, daddr_a, dstore_a, load_a;
  logic [1:0]  state_a;
  // LAT=0 instance
  logic        ren_b, wen_b, dwen_b, dwait_b;
  logic [31:0] addr_b, store_b, daddr_b, dstore_b, load_b;
  logic [1:0]  state_b;

  int checks   = 0;
  int failures = 0;

  ram_latency_model #(.LAT(2), .DEPTH(1024)) u_dut_a (
    .CLK(clk), .RST(rst),
    .ramREN(ren_a), .ramWEN(wen_a), .ramaddr(addr_a), .ramstore(store_a),
    .ramload(load_a), .ramstate(state_a),
    .dbg_WEN(dwen_a), .dbg_addr(daddr_a), .dbg_store(dstore_a), .dbg_wait(dwait_a)
  );

  ram_latency_model #(.LAT(0), .DEPTH(1024)) u_dut_b (
    .CLK(clk), .RST(rst),
    .ramREN(ren_b), .ramWEN(wen_b), .ramaddr(addr_b), .ramstore(store_b),
    .ramload(load_b), .ramstate(state_b),
    .dbg_WEN(dwen_b), .dbg_addr(daddr_b), .dbg_store(dstore_b), .dbg_wait(dwait_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  st;
    logic [31:0] ld;
    logic        dw;
  } vec_t;

  typedef struct {
    bit          sel;
    int          id;
    logic [1:0]  st;
    logic [31:0] ld;
    logic        dw;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] store,
                              input logic dwen, input logic [31:0] daddr,
                              input logic [31:0] dstore, input logic [1:0] st,
                              input logic [31:0] ld, input logic dw);
    vec_t v;
    v.rst = r; v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
    v.dwen = dwen; v.daddr = daddr; v.dstore = dstore;
    v.st = st; v.ld = ld; v.dw = dw;
    return v;
  endfunction

  // Shorthand for a CPU-only cycle.
  function automatic vec_t cpu(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] store, input logic [1:0] st,
                               input logic [31:0] ld);
    return mk(1'b0, ren, wen, addr, store, 1'b0, 32'd0, 32'd0, st, ld, 1'b0);
  endfunction

  task automatic cmp(input int id, input string what, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, what, act, req);
    end
  endtask

  // Drive one cycle, push the expectation, pop and compare at the falling edge.
  task automatic apply(input vec_t v, input bit sel, input int id);
    exp_t e;
    logic [1:0]  st;
    logic [31:0] ld;
    logic        dw;
    @(posedge clk);
    #1;
    rst = v.rst;
    ren_a = 0; wen_a = 0; addr_a = 0; store_a = 0; dwen_a = 0; daddr_a = 0; dstore_a = 0;
    ren_b = 0; wen_b = 0; addr_b = 0; store_b = 0; dwen_b = 0; daddr_b = 0; dstore_b = 0;
    if (!sel) begin
      ren_a = v.ren; wen_a = v.wen; addr_a = v.addr; store_a = v.store;
      dwen_a = v.dwen; daddr_a = v.daddr; dstore_a = v.dstore;
    end else begin
      ren_b = v.ren; wen_b = v.wen; addr_b = v.addr; store_b = v.store;
      dwen_b = v.dwen; daddr_b = v.daddr; dstore_b = v.dstore;
    end
    sb.push_back('{sel: sel, id: id, st: v.st, ld: v.ld, dw: v.dw});
    @(negedge clk);
    e  = sb.pop_front();
    st = e.sel ? state_b : state_a;
    ld = e.sel ? load_b  : load_a;
    dw = e.sel ? dwait_b : dwait_a;
    cmp(e.id, "ramstate", {30'd0, st}, {30'd0, e.st});
    cmp(e.id, "ramload", ld, e.ld);
    cmp(e.id, "dbg_wait", {31'd0, dw}, {31'd0, e.dw});
    $display("vec%0d dut=%0s state=%0d load=0x%08h dbg_wait=%0b", e.id,
             e.sel ? "LAT0" : "LAT2", st, ld, dw);
  endtask

  initial begin
    rst = 1;
    ren_a = 0; wen_a = 0; addr_a = 0; store_a = 0; dwen_a = 0; daddr_a = 0; dstore_a = 0;
    ren_b = 0; wen_b = 0; addr_b = 0; store_b = 0; dwen_b = 0; daddr_b = 0; dstore_b = 0;

    // Reset state
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_FREE, 0, 0));
    // Read 0x10: BUSY, BUSY, ACCESS, then held -> fresh BUSY
    vecs.push_back(cpu(1, 0, 32'h10, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h10, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h10, 0, S_ACC, 0));
    vecs.push_back(cpu(1, 0, 32'h10, 0, S_BUSY, 0));
    // Debug write while idle, then read it back; held debug write waits during BUSY
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, S_FREE, 0, 0));
    vecs.push_back(cpu(1, 0, 32'h40, 0, S_BUSY, 0));
    vecs.push_back(mk(0, 1, 0, 32'h40, 0, 1, 32'h44, 32'h11111111, S_BUSY, 0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h40, 0, 1, 32'h44, 32'h11111111, S_ACC, 32'hDEADBEEF, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h44, 32'h11111111, S_FREE, 0, 0));
    vecs.push_back(cpu(1, 0, 32'h44, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h44, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h44, 0, S_ACC, 32'h11111111));
    // Write 0x80, then read back
    vecs.push_back(cpu(0, 1, 32'h80, 32'h12345678, S_BUSY, 0));
    vecs.push_back(cpu(0, 1, 32'h80, 32'h12345678, S_BUSY, 0));
    vecs.push_back(cpu(0, 1, 32'h80, 32'h12345678, S_ACC, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_ACC, 32'h12345678));
    // Write 0x80 abandoned after one BUSY, switched to 0x84: count restarts
    vecs.push_back(cpu(0, 1, 32'h80, 32'hAAAA0000, S_BUSY, 0));
    vecs.push_back(cpu(0, 1, 32'h84, 32'hAAAA0000, S_BUSY, 0));
    vecs.push_back(cpu(0, 1, 32'h84, 32'hAAAA0000, S_BUSY, 0));
    vecs.push_back(cpu(0, 1, 32'h84, 32'hAAAA0000, S_ACC, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_ACC, 32'h12345678));
    vecs.push_back(cpu(1, 0, 32'h84, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h84, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h84, 0, S_ACC, 32'hAAAA0000));
    // ERROR cases; debug write is also held off while ERROR
    vecs.push_back(mk(0, 1, 1, 32'h80, 32'h0, 1, 32'h80, 32'h0BAD0BAD, S_ERR, 0, 1));
    vecs.push_back(cpu(0, 1, 32'h1000, 32'hFFFFFFFF, S_ERR, 0));
    vecs.push_back(cpu(0, 1, 32'h1000, 32'hFFFFFFFF, S_ERR, 0));
    vecs.push_back(cpu(0, 1, 32'h1000, 32'hFFFFFFFF, S_ERR, 0));
    vecs.push_back(cpu(1, 0, 32'h1000, 0, S_ERR, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h80, 0, S_ACC, 32'h12345678));
    // Out-of-range debug write accepted and dropped (must not alias onto word 0)
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h2000, 32'h55555555, S_FREE, 0, 0));
    vecs.push_back(cpu(1, 0, 32'h0, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h0, 0, S_BUSY, 0));
    vecs.push_back(cpu(1, 0, 32'h0, 0, S_ACC, 0));

    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], 1'b0, i);
    end

    // Reset during BUSY of a write: aborted, FREE once released with request dropped,
    // and memory cleared by the reset.
    apply(cpu(0, 1, 32'h100, 32'hCAFEF00D, S_BUSY, 0), 1'b0, 100);
    apply(mk(1, 0, 1, 32'h100, 32'hCAFEF00D, 0, 0, 0, S_BUSY, 0, 0), 1'b0, 101);
    apply(cpu(0, 0, 0, 0, S_FREE, 0), 1'b0, 102);
    apply(cpu(1, 0, 32'h80, 0, S_BUSY, 0), 1'b0, 103);
    apply(cpu(1, 0, 32'h80, 0, S_BUSY, 0), 1'b0, 104);
    apply(cpu(1, 0, 32'h80, 0, S_ACC, 0), 1'b0, 105);
    // After reset the write must restart from zero count
    apply(cpu(0, 1, 32'h100, 32'hCAFEF00D, S_BUSY, 0), 1'b0, 106);
    apply(cpu(0, 1, 32'h100, 32'hCAFEF00D, S_BUSY, 0), 1'b0, 107);
    apply(cpu(0, 1, 32'h100, 32'hCAFEF00D, S_ACC, 0), 1'b0, 108);
    apply(cpu(1, 0, 32'h100, 0, S_BUSY, 0), 1'b0, 109);
    apply(cpu(1, 0, 32'h100, 0, S_BUSY, 0), 1'b0, 110);
    apply(cpu(1, 0, 32'h100, 0, S_ACC, 32'hCAFEF00D), 1'b0, 111);

    // LAT=0 instance: ACCESS in the first cycle
    apply(cpu(1, 0, 32'h0, 0, S_ACC, 0), 1'b1, 200);
    apply(cpu(0, 1, 32'h8, 32'h00000077, S_ACC, 0), 1'b1, 201);
    apply(cpu(1, 0, 32'h8, 0, S_ACC, 32'h00000077), 1'b1, 202);
    apply(cpu(1, 0, 32'h8, 0, S_ACC, 32'h00000077), 1'b1, 203);
    apply(cpu(1, 1, 32'h8, 0, S_ERR, 0), 1'b1, 204);
    apply(mk(0, 0, 0, 0, 0, 1, 32'hC, 32'h00000099, S_FREE, 0, 0), 1'b1, 205);
    apply(cpu(1, 0, 32'hC, 0, S_ACC, 32'h00000099), 1'b1, 206);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_latency_model.md
Name: ram_latency_model

Overview:
- Word-organised main-memory model sitting directly downstream of the coherence/arbitration controller.
- Consumes the controller's single RAM request port (ramREN/ramWEN/ramaddr/ramstore) and returns ramstate and ramload with a programmable access latency.
- Provides a side-band debug write port so benches can preload program/data images between CPU requests.

Parameters:
- LAT, 2, number of BUSY cycles before the ACCESS cycle of every transaction; legal range 0..15.
- DEPTH, 1024, number of 32-bit words stored; addresses are word-indexed by ramaddr[31:2].

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ramREN  in  1  read request from memory controller
- ramWEN  in  1  write request from memory controller
- ramaddr  in  32  byte address; bits [1:0] ignored
- ramstore  in  32  write data
- ramload  out  32  read data, valid only in ACCESS cycle of a read
- ramstate  out  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3 (ramstate_t encoding)
- dbg_WEN  in  1  debug write request, held until accepted
- dbg_addr  in  32  debug byte address; bits [1:0] ignored
- dbg_store  in  32  debug write data
- dbg_wait  out  1  high while a held debug write is not being accepted this cycle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Registers: cnt[3:0], tracked_valid, tracked_addr[29:0], tracked_op (0=read, 1=write), and mem[DEPTH].
- Reset (RST high at an edge): cnt=0, tracked_valid=0, all mem words = 0.
  - Outputs after reset: ramstate=FREE, ramload=0, dbg_wait=dbg_WEN.
  - Reset mid-transaction aborts it; no write commits on that edge.
- req = ramREN | ramWEN. match = tracked_valid & (ramaddr[31:2]==tracked_addr) & (ramWEN==tracked_op). eff = match ? cnt : 0.
- ramstate, evaluated combinationally by priority:
  - ERROR if ramREN & ramWEN, or req & (ramaddr[31:2] >= DEPTH).
  - FREE if !req.
  - ACCESS if eff == LAT.
  - BUSY otherwise.
- ramload = mem[ramaddr[31:2]] when ramstate==ACCESS and ramREN; 0 otherwise. Read path is combinational from the array.
- Write commit: mem[ramaddr[31:2]] <= ramstore at the edge ending an ACCESS cycle with ramWEN.
- Next-state at each edge:
  - ACCESS: tracked_valid=0, cnt=0. A request held unchanged on the next cycle is a new transaction and pays LAT again.
  - BUSY: tracked_valid=1, tracked_addr/op captured, cnt=eff+1.
  - FREE or ERROR: tracked_valid=0, cnt=0. ERROR never writes memory.
- Request change mid-transaction (address or op differs while BUSY): the in-flight transaction is abandoned without a write, and the count restarts at 0 in that same cycle.
- Latency: a request first asserted in cycle t returns ACCESS in cycle t+LAT. With LAT=0, ACCESS occurs in cycle t.
- Debug port:
  - A dbg write is accepted only in a cycle where ramstate==FREE: mem[dbg_addr[31:2]] <= dbg_store at that edge, and dbg_wait=0 in that cycle.
  - Otherwise dbg_wait = dbg_WEN.
  - An out-of-range dbg_addr is accepted (dbg_wait=0) and dropped.
  - A CPU request always has priority, and the debug port never disturbs cnt or the tracked state.
- Simultaneous debug write and CPU read to the same word cannot occur, because debug acceptance requires !req.

Test Plan:
- Reset, then ramREN=1, addr=0x10, LAT=2 → ramstate BUSY, BUSY, ACCESS with ramload=0; next cycle with request held → BUSY again (fresh transaction).
- dbg write 0xDEADBEEF to 0x40 while idle (dbg_wait=0 that cycle), then ramREN addr 0x40 → ACCESS in cycle 3, ramload=0xDEADBEEF; dbg write held during BUSY sees dbg_wait=1 until FREE.
- ramWEN addr 0x80 data 0x12345678 held 3 cycles, then ramREN 0x80 → read returns 0x12345678 at its ACCESS.
- Write to 0x80 with data 0xAAAA0000 started, address switched to 0x84 after 1 BUSY cycle → count restarts (2 more BUSY cycles, then ACCESS); 0x80 is never written and still reads its prior value.
- ramREN & ramWEN together, or addr 0x1000 with DEPTH=1024 → ramstate=ERROR, ramload=0, memory unchanged.
- LAT=0 instance: ramREN addr 0x0 → ACCESS in the first cycle. Separately, RST asserted during BUSY of a write → no commit; ramstate=FREE the cycle after reset is released with the request dropped.
